// File: rtl/stack_queue_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : stack_queue_pkg                                             |
// | Brief   : Mode type and seven-segment encoding shared by the design.  |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
package stack_queue_pkg;

    typedef enum logic {
        LIFO = 1'b0,
        FIFO = 1'b1
    } mode_e;

    // Segment patterns {g,f,e,d,c,b,a}, indexed by hex digit (entry 0 is the LSB slice).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        return SEG_HEX[digit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_pulse.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : btn_pulse                                                   |
// | Brief   : Synchronise and debounce a raw button; one pulse per press. |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
module btn_pulse #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // A new level is accepted on its DEB_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
            r_pulse <= 1'b0;
            if (r_sync1 != r_stable) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_stable <= r_sync1;
                    r_cnt    <= '0;
                    r_pulse  <= r_sync1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/stack_queue_display.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : stack_queue_display                                         |
// | Brief   : Button-driven LIFO/FIFO with hex seven-segment readout.     |
// |           Optional sticky err output: STACK_QUEUE_ERR_FLAG_EN.        |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
module stack_queue_display
    import stack_queue_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn,
    input  logic                       enable,
    input  logic                       push_pop,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           data_out,
`ifdef STACK_QUEUE_ERR_FLAG_EN
    output logic                       err,
`endif
    output logic [6:0]                 Sout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    mode_e            r_mode;

    logic             w_op;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_tail_inc;
    logic [PW-1:0]    w_tail_dec;
    logic [PW-1:0]    w_head_inc;
    logic [PW-1:0]    w_rd_idx;

    btn_pulse #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_pulse (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .pulse (w_op)
    );

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_op & enable & push_pop & ~w_full;
    assign w_pop   = w_op & enable & ~push_pop & ~w_empty;

    // Explicit wrap so non-power-of-two depths stay in range.
    assign w_tail_inc = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
    assign w_tail_dec = (r_tail == '0) ? PW'(DEPTH - 1) : r_tail - 1'b1;
    assign w_head_inc = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mode  <= LIFO;
        end else begin
            if (w_empty) begin
                r_mode <= mode_e'(mode);
            end
            if (w_push) begin
                r_tail  <= w_tail_inc;
                r_count <= r_count + 1'b1;
            end else if (w_pop) begin
                if (r_mode == FIFO) begin
                    r_head <= w_head_inc;
                end else begin
                    r_tail <= w_tail_dec;
                end
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_tail] <= data_in;
        end
    end

`ifdef STACK_QUEUE_ERR_FLAG_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_op && enable && ((push_pop && w_full) || (!push_pop && w_empty))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign w_rd_idx = (r_mode == FIFO) ? r_head : w_tail_dec;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign data_out = w_empty ? '0 : r_mem[w_rd_idx];
    assign Sout     = w_empty ? SEG_DASH : hex_to_seg(data_out[3:0]);

endmodule
`default_nettype wire
